multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
Parametrised successor to the single-cycle ALU/comparator pair in the execution stage.
- Accepts one operation per valid/ready handshake and returns a registered result plus comparison flags on an output valid/ready channel.
- Adds logic ops, SLT/SLTU and an iterative shifter that moves SHIFT_STEP bits per cycle, so shifts cost latency instead of a full barrel shifter.
- Sits between decode/operand-fetch and writeback in the core.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of 2, >= 8.
- SHIFT_STEP, 1: bits shifted per iteration cycle; power of 2, 1..DATA_WIDTH.
- OP_WIDTH, 4: width of op field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  OP_WIDTH  operation code (package encoding).
- din1  in  DATA_WIDTH  operand 1.
- din2  in  DATA_WIDTH  operand 2 / shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- dout  out  DATA_WIDTH  result.
- comp  out  3  {ltu, lt, eq} of din1 vs din2, registered at accept.
- busy  out  1  high while in SHIFT state.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, dout=0, comp=0, busy=0. Any in-flight operation is discarded; no result is produced for it.
- States:
  - IDLE: accept when in_valid && in_ready. Operands and op are latched at the accepting edge.
  - SHIFT: iterate. busy=1.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE && !out_valid) || (state==HOLD && out_ready). Back-to-back issue is allowed in the consume cycle.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, NOP, undefined codes):
  - Accept at edge N, out_valid=1 after edge N. Latency 1.
  - NOP and undefined codes give dout=0, never X.
- SLT/SLTU: dout = zero-extended lt/ltu.
- comp:
  - eq = (din1==din2).
  - lt = signed din1 < signed din2.
  - ltu = unsigned din1 < unsigned din2.
  - Valid with every result, including shifts.
- Wrap-around: ADD/SUB are modulo 2^DATA_WIDTH; no carry or overflow output.
- Shifts (SLL, SRL, SRA):
  - amount = din2[log2(DATA_WIDTH)-1:0]; upper bits are ignored.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining).
  - SRA fills with the original sign bit.
  - Latency = 1 + ceil(amount/SHIFT_STEP).
  - amount=0 goes straight to HOLD with latency 1.
- Backpressure: while out_valid && !out_ready, dout and comp hold stable and in_ready=0 (in HOLD with out_ready=0).
- Consume and accept in the same edge: the old result is dropped and the new one loads. out_valid stays 1 if the new op is single-cycle, otherwise goes 0 until the shift completes.
- in_valid while not in_ready: ignored. The requester must hold its request.
- No X propagation from undriven op values into state.

Decomposition:
- Shared header/package holds:
  - ALU op encodings: NOP 0, ADD 1, SUB 2, AND 3, OR 4, XOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10.
  - COMP bit indices: EQ 0, LT 1, LTU 2.
  - State encodings.
  - Default DATA_WIDTH.
- Sub-module alu_compare_unit (combinational eq/lt/ltu, parametrised by DATA_WIDTH), instantiated once.

Test Plan:
- Reset, then ADD din1=5, din2=7 -> out_valid one cycle after accept, dout=12, comp={ltu=1, lt=1, eq=0}.
- SUB din1=0, din2=1 -> dout=0xFFFFFFFF. Compare din1=0xFFFFFFFF, din2=1 -> lt=1, ltu=0, eq=0.
- SRA din1=0x80000000, din2=31, SHIFT_STEP=1 -> out_valid 32 cycles after accept, dout=0xFFFFFFFF, busy high for 31 cycles. Repeat with SHIFT_STEP=4 -> latency 9. SLL with din2=0x20 -> amount 0, latency 1, dout=din1.
- Backpressure: out_ready=0 for 5 cycles after ADD result -> dout/comp stable, in_ready=0. Then out_ready=1 with a new SUB presented -> SUB accepted the same edge, next cycle shows the SUB result.
- Reset asserted asynchronously mid-SHIFT (SLL amount 20, cycle 8) -> out_valid, busy, dout go 0 immediately. After release, state is IDLE and the next ADD completes normally.
- Undefined op code 15 with din1=3, din2=3 -> dout=0, comp eq=1, latency 1.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: op codes, compare-flag indices, FSM states and default widths
// shared by the multicycle ALU, its interface and sub-modules.
package multicycle_alu_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF = 4;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } alu_op_e;
  localparam int COMP_EQ = 0;
  localparam int COMP_LT = 1;
  localparam int COMP_LTU = 2;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_e;
endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response handshake bundle between the issuing stage
// (master) and the multicycle ALU (slave).
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = multicycle_alu_pkg::DATA_WIDTH_DEF,
  parameter int OP_WIDTH = multicycle_alu_pkg::OP_WIDTH_DEF
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic [2:0]            comp;
  logic                  busy;
  modport master (
    output in_valid, op, din1, din2, out_ready,
    input  in_ready, out_valid, dout, comp, busy
  );
  modport slave (
    input  in_valid, op, din1, din2, out_ready,
    output in_ready, out_valid, dout, comp, busy
  );
endinterface

// File: rtl/multicycle_alu_compare_unit.sv
// alu_compare_unit: combinational eq / signed lt / unsigned lt of two operands.
module alu_compare_unit
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [2:0]            o_comp
);
  always_comb begin
    o_comp = '0;
    o_comp[COMP_EQ] = i_a == i_b;
    o_comp[COMP_LT] = $signed(i_a) < $signed(i_b);
    o_comp[COMP_LTU] = i_a < i_b;
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU; logic/arith/compare ops finish in one cycle,
// shifts iterate SHIFT_STEP bits per cycle in a working register.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SHIFT_STEP = 1,
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  multicycle_alu_if.slave bus
);
  localparam int AW = $clog2(DATA_WIDTH);
  localparam logic [AW:0] STEP = (AW+1)'(SHIFT_STEP);
  state_e r_state, w_next;
  logic [DATA_WIDTH-1:0] r_dout, w_res, w_shifted;
  logic [2:0] r_comp, w_comp;
  logic [AW-1:0] r_rem, w_amt;
  logic [AW:0] w_step, w_left;
  logic [1:0] r_kind, w_kind;
  logic w_accept, w_is_shift;

  function automatic logic is_op(logic [OP_WIDTH-1:0] o, alu_op_e e);
    return o == OP_WIDTH'(e);
  endfunction

  alu_compare_unit #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .i_a(bus.din1), .i_b(bus.din2), .o_comp(w_comp)
  );

  assign w_amt = bus.din2[AW-1:0];
  assign w_is_shift = is_op(bus.op, OP_SLL) || is_op(bus.op, OP_SRL) || is_op(bus.op, OP_SRA);
  assign w_kind = is_op(bus.op, OP_SRA) ? 2'd2 : is_op(bus.op, OP_SRL) ? 2'd1 : 2'd0;
  assign w_accept = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (r_state == S_IDLE) || (r_state == S_HOLD && bus.out_ready);
  assign bus.out_valid = r_state == S_HOLD;
  assign bus.busy = r_state == S_SHIFT;
  assign bus.dout = r_dout;
  assign bus.comp = r_comp;

  // Shift ops load din1 as the starting value of the working register.
  always_comb begin
    w_res = is_op(bus.op, OP_ADD)  ? bus.din1 + bus.din2 :
            is_op(bus.op, OP_SUB)  ? bus.din1 - bus.din2 :
            is_op(bus.op, OP_AND)  ? bus.din1 & bus.din2 :
            is_op(bus.op, OP_OR)   ? bus.din1 | bus.din2 :
            is_op(bus.op, OP_XOR)  ? bus.din1 ^ bus.din2 :
            is_op(bus.op, OP_SLT)  ? DATA_WIDTH'(w_comp[COMP_LT]) :
            is_op(bus.op, OP_SLTU) ? DATA_WIDTH'(w_comp[COMP_LTU]) :
            w_is_shift             ? bus.din1 : '0;
  end

  assign w_step = ({1'b0, r_rem} < STEP) ? {1'b0, r_rem} : STEP;
  assign w_left = {1'b0, r_rem} - w_step;
  // Sign bit never moves under >>>, so each step refills with the original sign.
  assign w_shifted = (r_kind == 2'd2) ? $unsigned($signed(r_dout) >>> w_step) :
                     (r_kind == 2'd1) ? r_dout >> w_step : r_dout << w_step;

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = (w_is_shift && w_amt != '0) ? S_SHIFT : S_HOLD;
    else if (r_state == S_SHIFT && w_left == '0) w_next = S_HOLD;
    else if (r_state == S_HOLD && bus.out_ready) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_comp <= '0;
      r_rem <= '0;
      r_kind <= '0;
    end else if (w_accept) begin
      r_dout <= w_res;
      r_comp <= w_comp;
      r_rem <= w_amt;
      r_kind <= w_kind;
    end else if (r_state == S_SHIFT) begin
      r_dout <= w_shifted;
      r_rem <= w_left[AW-1:0];
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed and randomized checks of the multicycle ALU against
// an arithmetic reference model, with SHIFT_STEP=1 and SHIFT_STEP=4 instances.
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_alu_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();
  multicycle_alu_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus4 ();

  multicycle_alu #(.DATA_WIDTH(32), .SHIFT_STEP(1), .OP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  multicycle_alu #(.DATA_WIDTH(32), .SHIFT_STEP(4), .OP_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  function automatic logic [31:0] m_res(int op, logic [31:0] a, logic [31:0] b);
    int amt = int'(b % 32);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return a << amt;
      9: return a >> amt;
      10: return $signed(a) >>> amt;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] m_comp(logic [31:0] a, logic [31:0] b);
    return {a < b, $signed(a) < $signed(b), a == b};
  endfunction

  function automatic int m_lat(int op, logic [31:0] b, int step);
    int amt = int'(b % 32);
    return (op >= 8 && op <= 10) ? 1 + (amt + step - 1) / step : 1;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int waits);
    logic rdy;
    bus.op = op; bus.din1 = a; bus.din2 = b; bus.in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1; waits++;
    end while (!rdy && waits < 200);
    bus.in_valid = 1'b0;
    n_checks++;
    if (!rdy) begin n_fail++; $display("FAIL issue_accept: in_ready=%b after %0d cycles, need 1", rdy, waits); end
  endtask

  task automatic wait_result(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
    n_checks++; if (bus.dout !== 32'd0) begin n_fail++; $display("FAIL reset_dout: got %h need 0", bus.dout); end
    n_checks++; if (bus.comp !== 3'd0) begin n_fail++; $display("FAIL reset_comp: got %b need 000", bus.comp); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
  endtask

  task automatic test_add();
    int w, lat, bn;
    issue(4'd1, 32'd5, 32'd7, w);
    wait_result(lat, bn);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d need 1", lat); end
    n_checks++; if (bus.dout !== 32'd12) begin n_fail++; $display("FAIL add_dout: got %h need %h", bus.dout, 32'd12); end
    n_checks++; if (bus.comp !== 3'b110) begin n_fail++; $display("FAIL add_comp: got %b need 110", bus.comp); end
  endtask

  task automatic test_sub_compare();
    int w, lat, bn;
    issue(4'd2, 32'd0, 32'd1, w);
    wait_result(lat, bn);
    n_checks++; if (bus.dout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %h need ffffffff", bus.dout); end
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, w);
    wait_result(lat, bn);
    n_checks++; if (bus.comp !== 3'b010) begin n_fail++; $display("FAIL cmp_neg_comp: got %b need 010", bus.comp); end
    n_checks++; if (bus.dout !== 32'd1) begin n_fail++; $display("FAIL slt_dout: got %h need 1", bus.dout); end
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, w);
    wait_result(lat, bn);
    n_checks++; if (bus.dout !== 32'd0) begin n_fail++; $display("FAIL sltu_dout: got %h need 0", bus.dout); end
  endtask

  task automatic test_shift();
    int w, lat, bn;
    issue(4'd10, 32'h8000_0000, 32'd31, w);
    wait_result(lat, bn);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL sra31_latency: got %0d need 32", lat); end
    n_checks++; if (bn !== 31) begin n_fail++; $display("FAIL sra31_busy_cycles: got %0d need 31", bn); end
    n_checks++; if (bus.dout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31_dout: got %h need ffffffff", bus.dout); end
    n_checks++; if (bus.comp !== m_comp(32'h8000_0000, 32'd31)) begin n_fail++; $display("FAIL sra31_comp: got %b need %b", bus.comp, m_comp(32'h8000_0000, 32'd31)); end
    issue(4'd8, 32'h1234_5678, 32'h20, w);
    wait_result(lat, bn);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sll0_latency: got %0d need 1", lat); end
    n_checks++; if (bus.dout !== 32'h1234_5678) begin n_fail++; $display("FAIL sll0_dout: got %h need 12345678", bus.dout); end
  endtask

  task automatic test_shift_step4();
    int lat;
    bus4.op = 4'd10; bus4.din1 = 32'h8000_0000; bus4.din2 = 32'd31; bus4.in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL step4_in_ready: got %b need 1", bus4.in_ready); end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== m_lat(10, 32'd31, 4)) begin n_fail++; $display("FAIL step4_latency: got %0d need %0d", lat, m_lat(10, 32'd31, 4)); end
    n_checks++; if (bus4.dout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL step4_dout: got %h need ffffffff", bus4.dout); end
    bus4.op = 4'd9; bus4.din1 = 32'hF000_0000; bus4.din2 = 32'd6; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL step4_srl6_latency: got %0d need 3", lat); end
    n_checks++; if (bus4.dout !== 32'h03C0_0000) begin n_fail++; $display("FAIL step4_srl6_dout: got %h need 03c00000", bus4.dout); end
  endtask

  task automatic test_backpressure();
    int w, lat, bn;
    logic [31:0] d0;
    logic [2:0] c0;
    bus.out_ready = 1'b0;
    issue(4'd1, 32'd100, 32'd23, w);
    wait_result(lat, bn);
    d0 = bus.dout; c0 = bus.comp;
    n_checks++; if (d0 !== 32'd123) begin n_fail++; $display("FAIL bp_dout: got %h need %h", d0, 32'd123); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.dout !== d0 || bus.comp !== c0 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid=%b dout=%h comp=%b in_ready=%b need 1 %h %b 0", i, bus.out_valid, bus.dout, bus.comp, bus.in_ready, d0, c0);
      end
    end
    bus.out_ready = 1'b1;
    issue(4'd2, 32'd50, 32'd8, w);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL bp_same_edge_accept: took %0d cycles need 1", w); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.dout !== 32'd42) begin n_fail++; $display("FAIL bp_next_result: valid=%b dout=%h need 1 %h", bus.out_valid, bus.dout, 32'd42); end
  endtask

  task automatic test_back_to_back();
    int w, lat, bn;
    issue(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, w);
    wait_result(lat, bn);
    issue(4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, w);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL b2b_accept: took %0d cycles need 1", w); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.dout !== 32'h0F00_0F00) begin n_fail++; $display("FAIL b2b_and: valid=%b dout=%h need 1 0f000f00", bus.out_valid, bus.dout); end
    issue(4'd9, 32'h8000_0000, 32'd4, w);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_shift_starts: valid=%b busy=%b need 0 1", bus.out_valid, bus.busy); end
    wait_result(lat, bn);
    n_checks++; if (bus.dout !== 32'h0800_0000) begin n_fail++; $display("FAIL b2b_srl: got %h need 08000000", bus.dout); end
  endtask

  task automatic test_async_reset();
    int w, lat, bn;
    issue(4'd8, 32'h0000_0ABC, 32'd20, w);
    repeat (7) begin @(posedge clk); #1; end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL arst_midshift_busy: got %b need 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 32'd0) begin
      n_fail++; $display("FAIL arst_clear: valid=%b busy=%b dout=%h need 0 0 0", bus.out_valid, bus.busy, bus.dout);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_idle: in_ready=%b need 1", bus.in_ready); end
    issue(4'd1, 32'd9, 32'd10, w);
    wait_result(lat, bn);
    n_checks++; if (lat !== 1 || bus.dout !== 32'd19) begin n_fail++; $display("FAIL arst_next_add: lat=%0d dout=%h need 1 %h", lat, bus.dout, 32'd19); end
  endtask

  task automatic test_undefined();
    int w, lat, bn;
    issue(4'd15, 32'd3, 32'd3, w);
    wait_result(lat, bn);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL undef_latency: got %0d need 1", lat); end
    n_checks++; if (bus.dout !== 32'd0) begin n_fail++; $display("FAIL undef_dout: got %h need 0", bus.dout); end
    n_checks++; if (bus.comp !== 3'b001) begin n_fail++; $display("FAIL undef_comp: got %b need 001", bus.comp); end
  endtask

  task automatic test_random();
    int w, lat, bn, op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 5))};
      issue(op[3:0], a, b, w);
      wait_result(lat, bn);
      n_checks++; if (lat !== m_lat(op, b, 1) || bus.dout !== m_res(op, a, b) || bus.comp !== m_comp(a, b)) begin
        n_fail++; $display("FAIL rand_%0d op=%0d a=%h b=%h: lat=%0d dout=%h comp=%b need %0d %h %b", i, op, a, b, lat, bus.dout, bus.comp, m_lat(op, b, 1), m_res(op, a, b), m_comp(a, b));
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = '0; bus.din1 = '0; bus.din2 = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.op = '0; bus4.din1 = '0; bus4.din2 = '0; bus4.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_compare();
    test_shift();
    test_shift_step4();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_undefined();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
